// File: rtl/ps2_key_sequencer_pkg.sv
// ps2_pkg: PS/2 byte constants, the key-event payload type and the
// decoder / LED-command FSM state enums shared by the sequencer files.
package ps2_pkg;

    localparam logic [7:0] PS2_E0 = 8'hE0;  // extended-key prefix
    localparam logic [7:0] PS2_F0 = 8'hF0;  // break (release) prefix
    localparam logic [7:0] PS2_FA = 8'hFA;  // keyboard ACK
    localparam logic [7:0] PS2_FE = 8'hFE;  // keyboard resend request
    localparam logic [7:0] PS2_AA = 8'hAA;  // self-test passed
    localparam logic [7:0] PS2_EE = 8'hEE;  // echo response
    localparam logic [7:0] PS2_ED = 8'hED;  // set-LEDs command

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ps2_evt_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_E0,
        D_F0,
        D_E0F0
    } dec_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_CMD,
        T_ACK1,
        T_ARG,
        T_ACK2
    } tx_state_t;

    // Bytes the keyboard sends for its own housekeeping; never key events
    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return (b == PS2_FA) || (b == PS2_FE) || (b == PS2_AA) ||
               (b == PS2_EE) || (b == 8'h00)  || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// ps2_key_sequencer_if: bundles the PS/2 byte-interface side, the key-event
// consumer side and the LED request side of the key sequencer.
// master = the sequencer, slave = its surroundings (PS/2 interface + game logic).
interface ps2_key_sequencer_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       ps2_busy;
    logic       ps2_err;
    logic [7:0] tx_data;
    logic       tx_write;

    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;
    logic       overflow;

    logic       led_req;
    logic [2:0] led_mask;
    logic       led_done;
    logic       led_fail;

    modport master (
        input  rx_data, rx_valid, ps2_busy, ps2_err,
        output tx_data, tx_write,
        output evt_valid, evt_code, evt_break, evt_ext, overflow,
        input  evt_ready,
        input  led_req, led_mask,
        output led_done, led_fail
    );

    modport slave (
        output rx_data, rx_valid, ps2_busy, ps2_err,
        input  tx_data, tx_write,
        input  evt_valid, evt_code, evt_break, evt_ext, overflow,
        output evt_ready,
        output led_req, led_mask,
        input  led_done, led_fail
    );

endinterface

// File: rtl/ps2_key_sequencer_evt_fifo.sv
// ps2_evt_fifo: show-ahead key-event FIFO. DEPTH must be a power of two
// (pointers wrap by natural overflow). A push into a full FIFO is dropped and
// latches the sticky overflow flag, unless a pop happens in the same cycle.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  ps2_evt_t din,
    input  logic     pop,
    output ps2_evt_t dout,
    output logic     full,
    output logic     empty,
    output logic     overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    ps2_evt_t      mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem      <= '{default: '0};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: turns the PS/2 scan-code byte stream into make/break key
// events (E0 = extended, F0 = break) buffered in ps2_evt_fifo, and optionally
// drives the host->keyboard set-LEDs command (ED + mask) with ACK wait,
// timeout and retry.
// Build option: define PS2_LED_CTRL_EN to include the LED command FSM;
// without it the transmit side and LED status outputs are tied to zero.
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned ACK_TIMEOUT = 2_500_000,
    parameter int unsigned MAX_RETRY   = 2
) (
    input logic                 clk,
    input logic                 reset,
    ps2_key_sequencer_if.master bus
);

    dec_state_t dec_state;
    logic       dec_push;
    ps2_evt_t   dec_evt;
    ps2_evt_t   head;
    logic       fifo_empty;
    logic       fifo_overflow;
    logic       fifo_full_unused;

    // Decoder output: does this byte complete a key event, and which kind
    always_comb begin
        dec_push = 1'b0;
        dec_evt  = '{brk: 1'b0, ext: 1'b0, code: bus.rx_data};
        if (bus.rx_valid && !bus.ps2_err) begin
            unique case (dec_state)
                D_IDLE: begin
                    if (bus.rx_data != PS2_E0 && bus.rx_data != PS2_F0 &&
                        !is_ctrl_byte(bus.rx_data)) begin
                        dec_push = 1'b1;
                    end
                end
                D_E0: begin
                    if (bus.rx_data != PS2_F0) begin
                        dec_push    = 1'b1;
                        dec_evt.ext = 1'b1;
                    end
                end
                D_F0: begin
                    dec_push    = 1'b1;
                    dec_evt.brk = 1'b1;
                end
                D_E0F0: begin
                    dec_push    = 1'b1;
                    dec_evt.brk = 1'b1;
                    dec_evt.ext = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Decoder prefix tracking; an interface error discards any partial sequence
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_state <= D_IDLE;
        end else if (bus.ps2_err) begin
            dec_state <= D_IDLE;
        end else if (bus.rx_valid) begin
            unique case (dec_state)
                D_IDLE: begin
                    if (bus.rx_data == PS2_E0) begin
                        dec_state <= D_E0;
                    end else if (bus.rx_data == PS2_F0) begin
                        dec_state <= D_F0;
                    end
                end
                D_E0: begin
                    dec_state <= (bus.rx_data == PS2_F0) ? D_E0F0 : D_IDLE;
                end
                default: dec_state <= D_IDLE;
            endcase
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (dec_push),
        .din      (dec_evt),
        .pop      (bus.evt_ready),
        .dout     (head),
        .full     (fifo_full_unused),
        .empty    (fifo_empty),
        .overflow (fifo_overflow)
    );

    assign bus.evt_valid = !fifo_empty;
    assign bus.evt_code  = head.code;
    assign bus.evt_break = head.brk;
    assign bus.evt_ext   = head.ext;
    assign bus.overflow  = fifo_overflow;

`ifdef PS2_LED_CTRL_EN

    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);

    tx_state_t     tx_state;
    logic [TW-1:0] timer;
    logic [RW-1:0] retries;
    logic [2:0]    mask;
    logic [7:0]    tx_data_q;
    logic          tx_write_q;
    logic          led_done_q;
    logic          led_fail_q;
    logic          ack;
    logic          nak;
    logic          timeout;

    assign ack     = bus.rx_valid && (bus.rx_data == PS2_FA);
    assign nak     = bus.rx_valid && (bus.rx_data == PS2_FE);
    assign timeout = (timer == TW'(ACK_TIMEOUT - 1));

    // LED command sequencer. The retry budget restarts for each byte once it
    // is ACKed; a resend goes out directly from the ACK-wait state when the
    // interface is free, otherwise it parks in T_CMD/T_ARG until it is.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state   <= T_IDLE;
            timer      <= '0;
            retries    <= '0;
            mask       <= '0;
            tx_data_q  <= '0;
            tx_write_q <= 1'b0;
            led_done_q <= 1'b0;
            led_fail_q <= 1'b0;
        end else begin
            tx_write_q <= 1'b0;
            led_done_q <= 1'b0;
            led_fail_q <= 1'b0;
            unique case (tx_state)
                T_IDLE: begin
                    if (bus.led_req && !bus.ps2_busy) begin
                        mask       <= bus.led_mask;
                        retries    <= '0;
                        timer      <= '0;
                        tx_data_q  <= PS2_ED;
                        tx_write_q <= 1'b1;
                        tx_state   <= T_ACK1;
                    end
                end
                T_CMD: begin
                    if (!bus.ps2_busy) begin
                        tx_write_q <= 1'b1;
                        timer      <= '0;
                        tx_state   <= T_ACK1;
                    end
                end
                T_ARG: begin
                    if (!bus.ps2_busy) begin
                        tx_write_q <= 1'b1;
                        timer      <= '0;
                        tx_state   <= T_ACK2;
                    end
                end
                T_ACK1, T_ACK2: begin
                    if (ack) begin
                        retries <= '0;
                        timer   <= '0;
                        if (tx_state == T_ACK1) begin
                            tx_data_q <= {5'b0, mask};
                            tx_state  <= T_ARG;
                        end else begin
                            led_done_q <= 1'b1;
                            tx_state   <= T_IDLE;
                        end
                    end else if (nak || timeout) begin
                        if (retries < RW'(MAX_RETRY)) begin
                            retries <= retries + 1'b1;
                            timer   <= '0;
                            if (!bus.ps2_busy) begin
                                tx_write_q <= 1'b1;
                            end else begin
                                tx_state <= (tx_state == T_ACK1) ? T_CMD : T_ARG;
                            end
                        end else begin
                            led_fail_q <= 1'b1;
                            tx_state   <= T_IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_write = tx_write_q;
    assign bus.led_done = led_done_q;
    assign bus.led_fail = led_fail_q;

`else

    localparam int unsigned cfg_unused = ACK_TIMEOUT + MAX_RETRY;
    logic tx_inputs_unused;

    assign tx_inputs_unused = ^{bus.led_req, bus.led_mask, bus.ps2_busy};
    assign bus.tx_data      = '0;
    assign bus.tx_write     = 1'b0;
    assign bus.led_done     = 1'b0;
    assign bus.led_fail     = 1'b0;

`endif

endmodule
